// File: rtl/cfu_pkg.sv
// Shared widths and the packed command word carried through the CFU command queue.
package cfu_pkg;

  localparam int CFU_FID_W  = 10;
  localparam int CFU_DATA_W = 32;

  // Field order here is the bit order of every FIFO word: function_id in the MSBs.
  typedef struct packed {
    logic [CFU_FID_W-1:0]  function_id;
    logic [CFU_DATA_W-1:0] inputs_0;
    logic [CFU_DATA_W-1:0] inputs_1;
  } cfu_cmd_t;

  localparam int CFU_CMD_W = $bits(cfu_cmd_t);

endpackage

// File: rtl/cfu_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered occupancy and no fall-through.
module cfu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + PTR_W'(1);
        2'b01:   level <= level - PTR_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is data-only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cfu_cmd_queue.sv
// Elastic CFU bridge: command FIFO toward the CFU, one-entry registered response slice back to the CPU.
module cfu_cmd_queue
  import cfu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FID_W  = CFU_FID_W,
  parameter int DATA_W = CFU_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FID_W-1:0]       cmd_payload_function_id,
  input  logic [DATA_W-1:0]      cmd_payload_inputs_0,
  input  logic [DATA_W-1:0]      cmd_payload_inputs_1,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_payload_outputs_0,
  output logic                   cfu_cmd_valid,
  input  logic                   cfu_cmd_ready,
  output logic [FID_W-1:0]       cfu_cmd_function_id,
  output logic [DATA_W-1:0]      cfu_cmd_inputs_0,
  output logic [DATA_W-1:0]      cfu_cmd_inputs_1,
  input  logic                   cfu_rsp_valid,
  output logic                   cfu_rsp_ready,
  input  logic [DATA_W-1:0]      cfu_rsp_outputs_0,
  output logic [$clog2(DEPTH):0] level
);

  localparam int WORD_W = FID_W + 2 * DATA_W;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] head_word;
  logic              rsp_vld_p1;
  logic [DATA_W-1:0] rsp_data_p1;
  logic              load;

  // cmd_ready depends only on registered state plus the reset pin, never on a pop.
  assign cmd_ready = !fifo_full && reset;
  assign push      = cmd_valid && cmd_ready;
  assign push_word = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};

  assign cfu_cmd_valid = !fifo_empty;
  assign pop           = cfu_cmd_valid && cfu_cmd_ready;
  assign {cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1} = head_word;

  cfu_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_word),
    .full      (fifo_full),
    .pop       (pop),
    .head_data (head_word),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Response slice: an empty or draining slice can always take the next result.
  assign cfu_rsp_ready = !rsp_vld_p1 || rsp_ready;
  assign load          = cfu_rsp_valid && cfu_rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else if (load) begin
      rsp_vld_p1  <= 1'b1;
      rsp_data_p1 <= cfu_rsp_outputs_0;
    end else if (rsp_ready) begin
      rsp_vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid             = rsp_vld_p1;
  assign rsp_payload_outputs_0 = rsp_data_p1;

endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Directed bench for cfu_cmd_queue with a combinational add/sub CFU attached.
module tb_cfu_cmd_queue;

  localparam int DEPTH  = 4;
  localparam int FID_W  = 10;
  localparam int DATA_W = 32;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [FID_W-1:0]  cmd_fid;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_payload;
  logic              cfu_cmd_valid;
  logic              cfu_cmd_ready;
  logic [FID_W-1:0]  cfu_fid;
  logic [DATA_W-1:0] cfu_a;
  logic [DATA_W-1:0] cfu_b;
  logic              cfu_rsp_valid;
  logic              cfu_rsp_ready;
  logic [DATA_W-1:0] cfu_rsp_out;
  logic [LW-1:0]     level;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] rsp_q[$];

  cfu_cmd_queue #(.DEPTH(DEPTH), .FID_W(FID_W), .DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_fid),
    .cmd_payload_inputs_0    (cmd_a),
    .cmd_payload_inputs_1    (cmd_b),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload),
    .cfu_cmd_valid           (cfu_cmd_valid),
    .cfu_cmd_ready           (cfu_cmd_ready),
    .cfu_cmd_function_id     (cfu_fid),
    .cfu_cmd_inputs_0        (cfu_a),
    .cfu_cmd_inputs_1        (cfu_b),
    .cfu_rsp_valid           (cfu_rsp_valid),
    .cfu_rsp_ready           (cfu_rsp_ready),
    .cfu_rsp_outputs_0       (cfu_rsp_out),
    .level                   (level)
  );

  // Combinational CFU: fid[0]=1 adds, fid[0]=0 subtracts.
  assign cfu_cmd_ready = cfu_rsp_ready;
  assign cfu_rsp_valid = cfu_cmd_valid;
  assign cfu_rsp_out   = cfu_fid[0] ? (cfu_a + cfu_b) : (cfu_a - cfu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) rsp_q.push_back(rsp_payload);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_fid = '0; cmd_a = '0; cmd_b = '0;
    #1 reset = 1'b0;
    cmd_valid = 1'b1; cmd_fid = 10'd1; cmd_a = 32'd7; cmd_b = 32'd7;
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_payload !== 32'd0) begin errors++; $display("FAIL reset_rsp_payload got=%h exp=0", rsp_payload); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (cfu_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cfu_cmd_valid got=%b exp=0", cfu_cmd_valid); end
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL post_reset_level got=%0d exp=0", level); end
  endtask

  task automatic test_single();
    rsp_q.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_fid = 10'd1; cmd_a = 32'd5; cmd_b = 32'd3;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_n1 got=%0d exp=1", level); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got=%b exp=0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid_n2 got=%b exp=1", rsp_valid); end
    checks++; if (rsp_payload !== 32'd8) begin errors++; $display("FAIL single_payload got=%0d exp=8", rsp_payload); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_n2 got=%0d exp=0", level); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int drops;
    int vbad;
    logic exp_v;
    logic [DATA_W-1:0] got;
    drops = 0; vbad = 0;
    rsp_q.delete();
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        cmd_valid = 1'b1; cmd_fid = 10'd0; cmd_a = 32'(100 + c); cmd_b = 32'(c);
        if (cmd_ready !== 1'b1) drops++;
      end else begin
        cmd_valid = 1'b0;
      end
      exp_v = (c >= 2 && c <= 9);
      if (rsp_valid !== exp_v) vbad++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_cmd_ready_drops got=%0d exp=0", drops); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL b2b_rsp_valid_pattern bad_cycles=%0d exp=0", vbad); end
    checks++; if (rsp_q.size() != 8) begin errors++; $display("FAIL b2b_rsp_count got=%0d exp=8", rsp_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== 32'd100) begin errors++; $display("FAIL b2b_rsp[%0d] got=%h exp=%h", i, got, 32'd100); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic acc;
    k = 0;
    rsp_q.delete();
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid = 1'b1; cmd_fid = 10'd1; cmd_a = 32'(1000 + k); cmd_b = 32'(k);
      acc = cmd_ready;
      step();
      if (acc) k++;
    end
    checks++; if (k != 5) begin errors++; $display("FAIL bp_accepted got=%0d exp=5", k); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got=%0d exp=4", level); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_payload !== 32'd1000) begin errors++; $display("FAIL bp_payload got=%0d exp=1000", rsp_payload); end
    cmd_a = 32'd1005; cmd_b = 32'd5;
    step(); step();
    checks++; if (rsp_payload !== 32'd1000) begin errors++; $display("FAIL bp_payload_stable got=%0d exp=1000", rsp_payload); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level_stable got=%0d exp=4", level); end
  endtask

  task automatic test_full_pop();
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp_v;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_fid = 10'd1; cmd_a = 32'd1005; cmd_b = 32'd5;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fullpop_no_push got=%b exp=0", cmd_ready); end
    step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL fullpop_level got=%0d exp=3", level); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_next got=%b exp=1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 20 && rsp_q.size() < 6; c++) step();
    step();
    checks++; if (rsp_q.size() != 6) begin errors++; $display("FAIL fullpop_rsp_count got=%0d exp=6", rsp_q.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_v = 32'(1000 + 2 * i);
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== exp_v) begin errors++; $display("FAIL fullpop_rsp[%0d] got=%0d exp=%0d", i, got, exp_v); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fullpop_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_wrap();
    localparam int N = 3 * DEPTH + 1;
    logic [DATA_W-1:0] wa [N];
    logic [DATA_W-1:0] wb [N];
    logic [DATA_W-1:0] wexp [N];
    logic [DATA_W-1:0] got;
    int idx;
    logic acc;
    for (int i = 0; i < N; i++) begin
      wa[i] = $urandom;
      wb[i] = $urandom;
      wexp[i] = (i % 2 == 1) ? (wa[i] + wb[i]) : (wa[i] - wb[i]);
    end
    idx = 0;
    rsp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (idx < N) begin
        cmd_valid = 1'b1; cmd_fid = 10'(idx); cmd_a = wa[idx]; cmd_b = wb[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) idx++;
      if (idx == N && rsp_q.size() == N) break;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++; if (idx != N) begin errors++; $display("FAIL wrap_accepted got=%0d exp=%0d", idx, N); end
    checks++; if (rsp_q.size() != N) begin errors++; $display("FAIL wrap_rsp_count got=%0d exp=%0d", rsp_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== wexp[i]) begin errors++; $display("FAIL wrap_rsp[%0d] got=%h exp=%h", i, got, wexp[i]); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic acc;
    k = 0;
    rsp_q.delete();
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (k < 4) begin
        cmd_valid = 1'b1; cmd_fid = 10'd0; cmd_a = 32'(50 + k); cmd_b = 32'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) k++;
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rstmid_level_before got=%0d exp=3", level); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_rsp_valid_before got=%b exp=1", rsp_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rstmid_async_level got=%0d exp=0", level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (cfu_cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cfu_cmd_valid got=%b exp=0", cfu_cmd_valid); end
    rsp_ready = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_ready_held got=%b exp=0", cmd_ready); end
    reset = 1'b1;
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_replay_rsp got=%b exp=0", rsp_valid); end
    checks++; if (cfu_cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_replay_cmd got=%b exp=0", cfu_cmd_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready_after got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_fid = 10'd1; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'd1;
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_payload !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_new_payload got=%h exp=00000000", rsp_payload); end
    step();
    checks++; if (rsp_q.size() != 1) begin errors++; $display("FAIL rstmid_rsp_count got=%0d exp=1", rsp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
